// File: rtl/timer_sequencer.sv
// Avalon-MM master that drives a 16-bit interval timer: programs the period,
// services timeouts, and takes atomic 64-bit counter snapshots.
//
// state  | meaning
// IDLE   | waiting for a command, cmd_ready high
// LOAD   | writing period halfwords to addresses 2..5
// GAP    | bus idle while the timer's reload settles
// CTRL   | writing START/ITO/CONT to the control register
// RUN    | timer running, arbitrating stop > irq > snapshot
// ACK    | clearing TO in status, pulsing tick
// SNAP_W | writing snapl to latch the counter
// SNAP_R | reading addresses 6..9, plus one trailing capture cycle
// STOP   | writing STOP to the control register
module timer_sequencer #(
  parameter int TICK_W     = 16,
  parameter int GAP_CYCLES = 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [63:0]       cmd_period,
  input  logic              cmd_continuous,
  input  logic              stop_req,
  input  logic              snap_req,
  output logic              snap_valid,
  output logic [63:0]       snap_value,
  output logic              tick,
  output logic [TICK_W-1:0] tick_count,
  output logic              done,
  output logic              busy,
  output logic [3:0]        tmr_address,
  output logic              tmr_chipselect,
  output logic              tmr_write_n,
  output logic [15:0]       tmr_writedata,
  input  logic [15:0]       tmr_readdata,
  input  logic              tmr_irq
);

  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  typedef enum logic [3:0] {
    IDLE, LOAD, GAP, CTRL, RUN, ACK, SNAP_W, SNAP_R, STOP
  } state_t;

  state_t          state, state_d;
  logic [2:0]      idx, idx_d;
  logic [GW-1:0]   gap_cnt, gap_d;
  logic [63:0]     period_q, period_src;
  logic            cont_q;
  logic            stop_pend, stop_pend_d;
  logic            snap_pend, snap_pend_d;
  logic            irq_mask, irq_eff;
  logic [47:0]     snap_acc;
  logic            cs_d, wn_d;
  logic [3:0]      addr_d;
  logic [15:0]     data_d;

  assign irq_eff    = tmr_irq && !irq_mask;
  // The first LOAD write is decided while still in IDLE, before period_q is loaded.
  assign period_src = (state == IDLE) ? cmd_period : period_q;

  assign cmd_ready = (state == IDLE);
  assign busy      = (state != IDLE);
  assign tick      = (state == ACK);
  assign done      = ((state == ACK) && !cont_q) || (state == STOP);

  always_comb begin
    state_d = state;
    idx_d   = '0;
    gap_d   = gap_cnt;
    case (state)
      IDLE:   if (cmd_valid) state_d = LOAD;
      LOAD: begin
        if (idx == 3'd3) begin
          state_d = GAP;
          gap_d   = GW'(GAP_CYCLES - 1);
        end else begin
          idx_d = idx + 3'd1;
        end
      end
      GAP: begin
        if (gap_cnt == '0) state_d = CTRL;
        else               gap_d   = gap_cnt - 1'b1;
      end
      CTRL:   state_d = RUN;
      RUN: begin
        if (stop_req || stop_pend)      state_d = STOP;
        else if (irq_eff)               state_d = ACK;
        else if (snap_req || snap_pend) state_d = SNAP_W;
      end
      ACK:    state_d = cont_q ? RUN : IDLE;
      SNAP_W: state_d = SNAP_R;
      SNAP_R: begin
        if (idx == 3'd4) state_d = RUN;
        else             idx_d   = idx + 3'd1;
      end
      STOP:   state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Bus outputs are decoded from the next state so the registered bus lines up with state.
    cs_d   = 1'b0;
    wn_d   = 1'b1;
    addr_d = 4'd0;
    data_d = 16'h0000;
    case (state_d)
      LOAD: begin
        cs_d   = 1'b1;
        wn_d   = 1'b0;
        addr_d = 4'd2 + {1'b0, idx_d};
        data_d = period_src[{idx_d[1:0], 4'b0000} +: 16];
      end
      CTRL: begin
        cs_d   = 1'b1;
        wn_d   = 1'b0;
        addr_d = 4'd1;
        data_d = 16'h0005 | {14'b0, cont_q, 1'b0};
      end
      ACK, SNAP_W: begin
        cs_d   = 1'b1;
        wn_d   = 1'b0;
        addr_d = (state_d == ACK) ? 4'd0 : 4'd6;
      end
      SNAP_R: begin
        if (idx_d != 3'd4) begin
          cs_d   = 1'b1;
          addr_d = 4'd6 + {1'b0, idx_d};
        end
      end
      STOP: begin
        cs_d   = 1'b1;
        wn_d   = 1'b0;
        addr_d = 4'd1;
        data_d = 16'h0008;
      end
      default: ;
    endcase

    stop_pend_d = (stop_pend || stop_req) && (state != RUN);
    snap_pend_d = (snap_pend || snap_req) && (state != IDLE) && !stop_pend_d &&
                  !((state == RUN) && (state_d == SNAP_W));
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state          <= IDLE;
      idx            <= '0;
      gap_cnt        <= '0;
      period_q       <= '0;
      cont_q         <= 1'b0;
      stop_pend      <= 1'b0;
      snap_pend      <= 1'b0;
      irq_mask       <= 1'b0;
      snap_acc       <= '0;
      snap_value     <= '0;
      snap_valid     <= 1'b0;
      tick_count     <= '0;
      tmr_chipselect <= 1'b0;
      tmr_write_n    <= 1'b1;
      tmr_address    <= 4'd0;
      tmr_writedata  <= 16'h0000;
    end else begin
      state          <= state_d;
      idx            <= idx_d;
      gap_cnt        <= gap_d;
      stop_pend      <= stop_pend_d;
      snap_pend      <= snap_pend_d;
      irq_mask       <= (state == ACK);
      snap_valid     <= 1'b0;
      tmr_chipselect <= cs_d;
      tmr_write_n    <= wn_d;
      tmr_address    <= addr_d;
      tmr_writedata  <= data_d;
      if ((state == IDLE) && cmd_valid) begin
        period_q   <= cmd_period;
        cont_q     <= cmd_continuous;
        tick_count <= '0;
      end
      if ((state == ACK) && (tick_count != '1))
        tick_count <= tick_count + 1'b1;
      // Read data trails its address by one cycle, so SNAP_R cycle n captures address 6+n-1.
      if (state == SNAP_R) begin
        case (idx)
          3'd1: snap_acc[15:0]  <= tmr_readdata;
          3'd2: snap_acc[31:16] <= tmr_readdata;
          3'd3: snap_acc[47:32] <= tmr_readdata;
          3'd4: begin
            snap_value <= {tmr_readdata, snap_acc};
            snap_valid <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_timer_sequencer.sv
// Directed bench for timer_sequencer with a small timer slave model
// (registered reads of a fixed snapshot pattern, irq driven by the sequence).
module tb_timer_sequencer;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [63:0] cmd_period;
  logic        cmd_continuous;
  logic        stop_req;
  logic        snap_req;
  logic        snap_valid;
  logic [63:0] snap_value;
  logic        tick;
  logic [1:0]  tick_count;
  logic        done;
  logic        busy;
  logic [3:0]  tmr_address;
  logic        tmr_chipselect;
  logic        tmr_write_n;
  logic [15:0] tmr_writedata;
  logic [15:0] tmr_readdata;
  logic        tmr_irq;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  timer_sequencer #(.TICK_W(2), .GAP_CYCLES(1)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .cmd_valid      (cmd_valid),
    .cmd_ready      (cmd_ready),
    .cmd_period     (cmd_period),
    .cmd_continuous (cmd_continuous),
    .stop_req       (stop_req),
    .snap_req       (snap_req),
    .snap_valid     (snap_valid),
    .snap_value     (snap_value),
    .tick           (tick),
    .tick_count     (tick_count),
    .done           (done),
    .busy           (busy),
    .tmr_address    (tmr_address),
    .tmr_chipselect (tmr_chipselect),
    .tmr_write_n    (tmr_write_n),
    .tmr_writedata  (tmr_writedata),
    .tmr_readdata   (tmr_readdata),
    .tmr_irq        (tmr_irq)
  );

  // Timer slave: snapshot halfwords at 6..9, one-cycle registered read latency.
  always @(posedge clk) begin
    if (tmr_chipselect && tmr_write_n) begin
      case (tmr_address)
        4'd6:    tmr_readdata <= 16'h1111;
        4'd7:    tmr_readdata <= 16'h2222;
        4'd8:    tmr_readdata <= 16'h3333;
        4'd9:    tmr_readdata <= 16'h4444;
        default: tmr_readdata <= 16'h0000;
      endcase
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance to the next falling edge; single-cycle request pulses end here.
  task automatic step();
    @(negedge clk);
    cmd_valid = 1'b0;
    stop_req  = 1'b0;
    snap_req  = 1'b0;
  endtask

  // Step until the next bus write, then check address/data and how many cycles it took.
  task automatic next_wr(input string tag, input logic [3:0] ea, input logic [15:0] ed,
                         input int ewait);
    int w = 0;
    bit found = 1'b0;
    while (!found && w < 30) begin
      step();
      w++;
      if (tmr_chipselect && !tmr_write_n) found = 1'b1;
    end
    if (!found) begin
      n_cmp++;
      n_err++;
      $error("FAIL %s: no write within %0d cycles, expected addr %h data %h", tag, w, ea, ed);
    end else begin
      chk(tag, {44'b0, tmr_address, tmr_writedata}, {44'b0, ea, ed});
      chk({tag, "_lat"}, 64'(w), 64'(ewait));
    end
  endtask

  // The SNAP_W write completes on the edge ending its cycle; snap_valid is
  // registered five edges after that, i.e. seen six falling edges later.
  task automatic wait_snap(input string tag, input logic [63:0] ev, input int ewait);
    int w = 0;
    bit found = 1'b0;
    while (!found && w < 20) begin
      step();
      w++;
      if (snap_valid) found = 1'b1;
    end
    if (!found) begin
      n_cmp++;
      n_err++;
      $error("FAIL %s: no snap_valid within %0d cycles, expected %h", tag, w, ev);
    end else begin
      chk(tag, snap_value, ev);
      chk({tag, "_lat"}, 64'(w), 64'(ewait));
    end
  endtask

  initial begin
    int seen;
    reset_n        = 1'b0;
    cmd_valid      = 1'b0;
    cmd_period     = '0;
    cmd_continuous = 1'b0;
    stop_req       = 1'b0;
    snap_req       = 1'b0;
    tmr_irq        = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_cmd_ready", cmd_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_write_n", tmr_write_n, 1);
    chk("rst_cs", tmr_chipselect, 0);
    chk("rst_snap_value", snap_value, 0);
    chk("rst_tick_count", tick_count, 0);
    reset_n = 1'b1;
    step();

    // One-shot run
    cmd_period = 64'h0000_0000_0001_86A0; cmd_continuous = 1'b0; cmd_valid = 1'b1;
    next_wr("os_p0", 4'd2, 16'h86A0, 1);
    chk("os_busy", busy, 1);
    chk("os_cmd_ready", cmd_ready, 0);
    next_wr("os_p1", 4'd3, 16'h0001, 1);
    next_wr("os_p2", 4'd4, 16'h0000, 1);
    next_wr("os_p3", 4'd5, 16'h0000, 1);
    next_wr("os_ctrl", 4'd1, 16'h0005, 2);
    step(); step();
    tmr_irq = 1'b1;
    next_wr("os_ack", 4'd0, 16'h0000, 1);
    chk("os_tick", tick, 1);
    chk("os_done", done, 1);
    tmr_irq = 1'b0;
    step();
    chk("os_tick_count", tick_count, 1);
    chk("os_idle_ready", cmd_ready, 1);
    chk("os_done_pulse", done, 0);

    // Continuous run, three timeouts
    cmd_period = 64'd10; cmd_continuous = 1'b1; cmd_valid = 1'b1;
    next_wr("c_p0", 4'd2, 16'h000A, 1);
    next_wr("c_p1", 4'd3, 16'h0000, 1);
    next_wr("c_p2", 4'd4, 16'h0000, 1);
    next_wr("c_p3", 4'd5, 16'h0000, 1);
    next_wr("c_ctrl", 4'd1, 16'h0007, 2);
    for (int i = 0; i < 3; i++) begin
      step(); step();
      tmr_irq = 1'b1;
      next_wr("c_ack", 4'd0, 16'h0000, 1);
      chk("c_tick", tick, 1);
      chk("c_done", done, 0);
      if (i < 2) tmr_irq = 1'b0;
    end
    // irq still high across the cycle after the last ACK must not retrigger
    step(); step();
    chk("irq_mask", tmr_chipselect, 0);
    tmr_irq = 1'b0;
    chk("c_tick_count", tick_count, 3);
    chk("c_busy", busy, 1);

    // Snapshot in RUN
    snap_req = 1'b1;
    next_wr("snap_w", 4'd6, 16'h0000, 1);
    wait_snap("snap", 64'h4444_3333_2222_1111, 6);
    step();
    chk("snap_valid_pulse", snap_valid, 0);

    // stop and irq together: stop wins
    stop_req = 1'b1; tmr_irq = 1'b1;
    next_wr("stop_vs_irq", 4'd1, 16'h0008, 1);
    chk("stop_done", done, 1);
    chk("stop_no_tick", tick, 0);
    tmr_irq = 1'b0;
    step();
    chk("stop_idle", busy, 0);

    // snap_req during LOAD is held until RUN
    cmd_period = 64'hDEAD_BEEF_0000_0010; cmd_continuous = 1'b1; cmd_valid = 1'b1;
    next_wr("l_p0", 4'd2, 16'h0010, 1);
    snap_req = 1'b1;
    next_wr("l_p1", 4'd3, 16'h0000, 1);
    next_wr("l_p2", 4'd4, 16'hBEEF, 1);
    next_wr("l_p3", 4'd5, 16'hDEAD, 1);
    next_wr("l_ctrl", 4'd1, 16'h0007, 2);
    next_wr("snap_pend", 4'd6, 16'h0000, 2);
    wait_snap("snap_pend_val", 64'h4444_3333_2222_1111, 6);

    // Five timeouts with a 2-bit counter saturate at 3
    for (int i = 0; i < 5; i++) begin
      step(); step();
      tmr_irq = 1'b1;
      next_wr("sat_ack", 4'd0, 16'h0000, 1);
      tmr_irq = 1'b0;
    end
    step();
    chk("tick_sat", tick_count, 3);
    stop_req = 1'b1;
    next_wr("sat_stop", 4'd1, 16'h0008, 1);
    step();

    // Reset in the middle of LOAD abandons the sequence
    cmd_period = 64'h1234_5678_9ABC_DEF0; cmd_continuous = 1'b0; cmd_valid = 1'b1;
    next_wr("r_p0", 4'd2, 16'hDEF0, 1);
    next_wr("r_p1", 4'd3, 16'h9ABC, 1);
    step();
    reset_n = 1'b0;
    #1;
    chk("r_cs", tmr_chipselect, 0);
    chk("r_write_n", tmr_write_n, 1);
    chk("r_addr", tmr_address, 0);
    chk("r_idle", cmd_ready, 1);
    step();
    reset_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      step();
      if (tmr_chipselect) seen++;
    end
    chk("r_quiet", 64'(seen), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
